adc_spi_sampler: RTL and testbench



---
 rtl/adc_spi_sampler.sv | 145 ++++++++++++++
 tb/tb_adc_spi_sampler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_sampler.sv
// One SPI mode-0 read of the front-end ADC per rising edge of the 512 kHz sample strobe.
// The strobe is edge-detected in the clk_in domain; ticks while a transfer is in flight raise overrun.
module adc_spi_sampler #(
    parameter int DATA_W    = 16,
    parameter int SCLK_HALF = 2,
    parameter int CS_SETUP  = 2,
    parameter int CS_HOLD   = 2
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              clk_512k,
    input  logic              en,
    input  logic              spi_miso,
    output logic              spi_sclk,
    output logic              spi_cs_n,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int PH_MAX0 = (SCLK_HALF > CS_SETUP) ? SCLK_HALF : CS_SETUP;
    localparam int PH_MAX  = (PH_MAX0 > CS_HOLD) ? PH_MAX0 : CS_HOLD;
    localparam int PH_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int BIT_W   = $clog2(DATA_W + 1);

    localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(SCLK_HALF - 1);
    localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(CS_HOLD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        r_state;
    logic [PH_W-1:0]   r_phase;
    logic [BIT_W-1:0]  r_bit;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data_out;
    logic              r_prev;
    logic              r_sclk;
    logic              r_cs_n;
    logic              r_data_valid;
    logic              r_overrun;
    logic              w_tick;
    logic              w_idle;

    assign w_tick = clk_512k & ~r_prev;
    assign w_idle = (r_state == S_IDLE);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_phase      <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_data_out   <= '0;
            r_prev       <= 1'b1;
            r_sclk       <= 1'b0;
            r_cs_n       <= 1'b1;
            r_data_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_prev       <= clk_512k;
            r_data_valid <= 1'b0;
            // Overrun is reported only; the transfer in flight is never restarted or stretched.
            r_overrun    <= w_tick & en & ~w_idle;
            case (r_state)
                S_IDLE: begin
                    r_sclk <= 1'b0;
                    if (w_tick && en) begin
                        r_state <= S_SETUP;
                        r_cs_n  <= 1'b0;
                        r_phase <= '0;
                        r_bit   <= '0;
                    end
                end
                S_SETUP: begin
                    if (r_phase == SETUP_LAST) begin
                        r_state <= S_SHIFT;
                        r_phase <= '0;
                        r_bit   <= '0;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_phase == HALF_LAST) begin
                        r_phase <= '0;
                        if (!r_sclk) begin
                            // Sample on the edge that raises SCLK: the ADC launched this bit on the prior fall.
                            r_sclk  <= 1'b1;
                            r_shift <= {r_shift[DATA_W-2:0], spi_miso};
                        end else begin
                            r_sclk <= 1'b0;
                            if (r_bit == BIT_LAST) begin
                                r_state <= S_HOLD;
                                r_bit   <= '0;
                            end else begin
                                r_bit <= r_bit + 1'b1;
                            end
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_phase == HOLD_LAST) begin
                        r_state      <= S_DONE;
                        r_phase      <= '0;
                        r_bit        <= '0;
                        r_cs_n       <= 1'b1;
                        r_data_out   <= r_shift;
                        r_data_valid <= 1'b1;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_phase <= '0;
                    r_bit   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_phase <= '0;
                    r_bit   <= '0;
                    r_sclk  <= 1'b0;
                    r_cs_n  <= 1'b1;
                end
            endcase
        end
    end

    assign spi_sclk   = r_sclk;
    assign spi_cs_n   = r_cs_n;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign busy       = ~w_idle;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler: an ADC serial model, a tick-level transfer model feeding an
// expected-sample queue, and a monitor that checks each data_valid against that queue.
module tb_adc_spi_sampler;

    localparam int DW     = 16;
    localparam int T_XFER = 2 + 2 * DW * 2 + 2;

    logic          clk_in   = 1'b0;
    logic          rst      = 1'b1;
    logic          clk_512k = 1'b0;
    logic          en       = 1'b0;
    logic          spi_miso = 1'b0;
    logic          spi_sclk;
    logic          spi_cs_n;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          busy;
    logic          overrun;

    adc_spi_sampler dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .clk_512k   (clk_512k),
        .en         (en),
        .spi_miso   (spi_miso),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            at;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] adc_q[$];
    exp_t          e;
    int            errors    = 0;
    int            checks    = 0;
    int            busy_lo   = -1000;
    int            busy_hi   = -1000;
    int            exp_ovr   = 0;
    int            got_ovr   = 0;
    int            exp_xfers = 0;
    int            got_xfers = 0;
    bit            glitch    = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Transfer model: a rising strobe with en high is serviced if the previous transfer's
    // 69-cycle busy window (E0..E0+68) has closed, otherwise it is an overrun.
    task automatic rise(input logic [DW-1:0] word);
        clk_512k = 1'b1;
        if (en) begin
            if (cyc >= busy_lo && cyc <= busy_hi) begin
                exp_ovr++;
            end else begin
                busy_lo = cyc + 1;
                busy_hi = cyc + 1 + T_XFER;
                exp_q.push_back('{word, cyc + 1 + T_XFER});
                adc_q.push_back(word);
                exp_xfers++;
            end
        end
    endtask

    task automatic pulse(input logic [DW-1:0] word, input int hi, input int lo);
        rise(word);
        step(hi);
        clk_512k = 1'b0;
        step(lo);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cs_n"}, 32'(spi_cs_n), 32'd1);
        check({tag, "_sclk"}, 32'(spi_sclk), 32'd0);
        check({tag, "_data_out"}, 32'(data_out), 32'd0);
        check({tag, "_data_valid"}, 32'(data_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    task automatic section_check(input string tag);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_overruns"}, 32'(got_ovr), 32'(exp_ovr));
        check({tag, "_transfers"}, 32'(got_xfers), 32'(exp_xfers));
    endtask

    // ADC model, scoreboard monitor and SPI frame checks, all away from the active edge.
    logic [DW-1:0] cur_word  = '0;
    int            bidx      = 0;
    bit            prev_cs   = 1'b1;
    bit            prev_sclk = 1'b0;
    int            rises     = 0;
    int            low_cyc   = 0;
    bit            win_rst   = 1'b0;

    always @(negedge clk_in) begin
        if (cyc > 0) begin
            if (!rst) begin
                if (data_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: got data %h at cycle %0d, expected no valid", data_out, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("valid_data", 32'(data_out), 32'(e.data));
                        check("valid_cycle", cyc, e.at);
                    end
                end
                if (overrun === 1'b1) got_ovr++;
            end

            if (prev_cs && !spi_cs_n) begin
                got_xfers++;
                rises   = 0;
                low_cyc = 0;
                win_rst = 1'b0;
                cur_word = (adc_q.size() != 0) ? adc_q.pop_front() : 16'hDEAD;
                bidx     = DW - 1;
                spi_miso = cur_word[bidx];
            end else if (!spi_cs_n && prev_sclk && !spi_sclk) begin
                bidx--;
                if (bidx >= 0) spi_miso = cur_word[bidx];
            end else if (!spi_cs_n && spi_sclk && glitch) begin
                spi_miso = ~spi_miso;
            end

            if (!spi_cs_n) low_cyc++;
            if (!spi_cs_n && !prev_sclk && spi_sclk) rises++;
            if (rst) win_rst = 1'b1;
            if (!prev_cs && spi_cs_n && !win_rst) begin
                check("sclk_rises", rises, DW);
                check("cs_low_cycles", low_cyc, T_XFER);
            end
            prev_cs   = spi_cs_n;
            prev_sclk = spi_sclk;
        end
    end

    initial begin
        logic [DW-1:0] w;

        rst = 1'b1;
        step(4);
        check_reset_state("reset");
        rst = 1'b0;
        en  = 1'b1;
        step(3);

        pulse(16'hA5C3, 10, 115);
        section_check("single");

        for (int i = 0; i < 10; i++) pulse(16'(i), 62, 63);
        section_check("freerun");

        pulse(16'h3C5A, 5, 25);
        pulse(16'h1111, 5, 120);
        section_check("overrun");

        rise(16'h7E81);
        step(5);
        clk_512k = 1'b0;
        step(15);
        rst = 1'b1;
        step(1);
        check_reset_state("midreset");
        rst = 1'b0;
        exp_q.delete();
        adc_q.delete();
        busy_lo = -1000;
        busy_hi = -1000;
        step(50);
        pulse(16'h5AA5, 10, 115);
        section_check("after_reset");

        en = 1'b0;
        for (int i = 0; i < 3; i++) pulse(16'hFFFF, 10, 115);
        section_check("en_low");
        en = 1'b1;
        rise(16'h0F0F);
        step(11);
        en       = 1'b0;
        clk_512k = 1'b0;
        step(114);
        section_check("en_drop");
        en = 1'b1;

        glitch = 1'b1;
        pulse(16'h8001, 10, 115);
        pulse(16'h7FFE, 10, 115);
        glitch = 1'b0;
        section_check("msb_first");

        for (int i = 0; i < 16; i++) begin
            w  = 16'($urandom);
            en = ($urandom_range(0, 3) != 0);
            pulse(w, $urandom_range(1, 40), $urandom_range(1, 140));
        end
        en = 1'b1;
        step(100);
        section_check("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
